// File: rtl/vdp_tmds_pkg.sv
// Shared TMDS definitions: control tokens, alignment state and symbol helpers.
// Used by both the transmit encoder and the receive decoder.
package vdp_tmds_pkg;

    localparam logic [9:0] TMDS_CTRL_00 = 10'h354;
    localparam logic [9:0] TMDS_CTRL_01 = 10'h0AB;
    localparam logic [9:0] TMDS_CTRL_10 = 10'h154;
    localparam logic [9:0] TMDS_CTRL_11 = 10'h2AB;

    typedef enum logic [0:0] {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } tmds_align_state_t;

    typedef struct packed {
        logic       de;
        logic [1:0] ctrl;
        logic [7:0] data;
    } tmds_sym_t;

    function automatic logic is_ctrl_token(input logic [9:0] sym);
        return (sym == TMDS_CTRL_00) || (sym == TMDS_CTRL_01) ||
               (sym == TMDS_CTRL_10) || (sym == TMDS_CTRL_11);
    endfunction

    function automatic logic [1:0] ctrl_code(input logic [9:0] sym);
        logic [1:0] code;
        code = 2'b00;
        unique case (1'b1)
            sym == TMDS_CTRL_01: code = 2'b01;
            sym == TMDS_CTRL_10: code = 2'b10;
            sym == TMDS_CTRL_11: code = 2'b11;
            default:             code = 2'b00;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational TMDS 10b symbol decode to {de, ctrl, data}.
// Control tokens give de=0 with their code; all else is pixel data.
module tmds_symbol_decode
    import vdp_tmds_pkg::*;
(
    input  logic [9:0] sym,
    output logic       de,
    output logic [1:0] ctrl,
    output logic [7:0] data
);

    logic [7:0] d;
    logic [7:0] x;
    logic [7:0] q;

    // Undo the optional inversion, then undo the XOR/XNOR chain.
    assign d = sym[9] ? ~sym[7:0] : sym[7:0];
    assign x = d ^ {d[6:0], 1'b0};
    assign q = sym[8] ? x : {~x[7:1], x[0]};

    always_comb begin
        de   = 1'b1;
        ctrl = 2'b00;
        data = q;
        if (is_ctrl_token(sym)) begin
            de   = 1'b0;
            ctrl = ctrl_code(sym);
            data = 8'h00;
        end
    end

endmodule

// File: rtl/tmds_rx_decoder.sv
// One TMDS receive channel: bit-slip word alignment on control-token runs.
// Define TMDS_LOCK_STATS_EN to add lock_loss_cnt and slip_cnt outputs.
module tmds_rx_decoder
    import vdp_tmds_pkg::*;
#(
    parameter int LOCK_RUN     = 16,
    parameter int SLIP_TIMEOUT = 2048,
    parameter int LOST_TIMEOUT = 4096
) (
    input  logic       clk_pix,
    input  logic       rst_pix,
    input  logic [9:0] sym_raw,
    output logic [7:0] data,
    output logic       de,
    output logic [1:0] ctrl,
    output logic       locked,
    output logic [3:0] offset
`ifdef TMDS_LOCK_STATS_EN
    ,
    output logic [7:0] lock_loss_cnt,
    output logic [7:0] slip_cnt
`endif
);

    localparam int RUN_W  = $clog2(LOCK_RUN + 1);
    localparam int MISS_W = $clog2(SLIP_TIMEOUT + 1);
    localparam int WD_W   = $clog2(LOST_TIMEOUT + 1);

    logic [9:0]  r0;
    logic [9:0]  sym_al;
    logic [9:0]  aligned;
    logic [19:0] window;

    tmds_align_state_t state;
    tmds_align_state_t state_n;

    logic [RUN_W-1:0]  run;
    logic [RUN_W-1:0]  run_n;
    logic [MISS_W-1:0] miss;
    logic [MISS_W-1:0] miss_n;
    logic [WD_W-1:0]   wd;
    logic [WD_W-1:0]   wd_n;
    logic [3:0]        offset_n;

    logic       dec_de;
    logic [1:0] dec_ctrl;
    logic [7:0] dec_data;
    logic       tok;

    tmds_sym_t out_n;

    // Older word sits in the low half so bit 0 is the earliest received.
    assign window  = {sym_raw, r0};
    assign aligned = window[{1'b0, offset} +: 10];

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            r0     <= '0;
            sym_al <= '0;
        end else begin
            r0     <= sym_raw;
            sym_al <= aligned;
        end
    end

    tmds_symbol_decode u_dec (
        .sym  (sym_al),
        .de   (dec_de),
        .ctrl (dec_ctrl),
        .data (dec_data)
    );

    assign tok = ~dec_de;

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            state  <= SEARCH;
            run    <= '0;
            miss   <= '0;
            wd     <= '0;
            offset <= '0;
        end else begin
            state  <= state_n;
            run    <= run_n;
            miss   <= miss_n;
            wd     <= wd_n;
            offset <= offset_n;
        end
    end

    always_comb begin
        state_n  = state;
        run_n    = run;
        miss_n   = miss;
        wd_n     = wd;
        offset_n = offset;
        unique case (state)
            SEARCH: begin
                if (tok) begin
                    run_n = run + RUN_W'(1);
                end else begin
                    run_n  = '0;
                    miss_n = miss + MISS_W'(1);
                end
                // Lock takes priority over a slip on the same cycle.
                if (run_n == RUN_W'(LOCK_RUN)) begin
                    state_n = LOCKED;
                    wd_n    = '0;
                end else if (miss_n == MISS_W'(SLIP_TIMEOUT)) begin
                    offset_n = (offset == 4'd9) ? 4'd0 : offset + 4'd1;
                    run_n    = '0;
                    miss_n   = '0;
                end
            end
            LOCKED: begin
                wd_n = tok ? '0 : wd + WD_W'(1);
                if (wd_n == WD_W'(LOST_TIMEOUT)) begin
                    state_n = SEARCH;
                    run_n   = '0;
                    miss_n  = '0;
                end
            end
        endcase
    end

    // Gate on the next state so the drop cycle already shows de=0.
    always_comb begin
        out_n      = '0;
        out_n.ctrl = 2'b00;
        if (state_n == LOCKED) begin
            if (tok) begin
                out_n.ctrl = dec_ctrl;
            end else begin
                out_n.de   = 1'b1;
                out_n.data = dec_data;
                out_n.ctrl = ctrl;
            end
        end
    end

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            data <= '0;
            de   <= 1'b0;
            ctrl <= '0;
        end else begin
            data <= out_n.data;
            de   <= out_n.de;
            ctrl <= out_n.ctrl;
        end
    end

    assign locked = (state == LOCKED);

`ifdef TMDS_LOCK_STATS_EN
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            lock_loss_cnt <= '0;
            slip_cnt      <= '0;
        end else begin
            if (state == LOCKED && state_n == SEARCH &&
                lock_loss_cnt != 8'hFF) begin
                lock_loss_cnt <= lock_loss_cnt + 8'd1;
            end
            if (offset_n != offset && slip_cnt != 8'hFF) begin
                slip_cnt <= slip_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tmds_rx_decoder.sv
// Bench for tmds_rx_decoder: directed alignment scenarios plus random traffic.
// A bit-stream reference model predicts every output on every cycle.
module tb_tmds_rx_decoder;

    localparam int LOCK_RUN     = 16;
    localparam int SLIP_TIMEOUT = 2048;
    localparam int LOST_TIMEOUT = 4096;

    logic       clk_pix;
    logic       rst_pix;
    logic [9:0] sym_raw;
    logic [7:0] data;
    logic       de;
    logic [1:0] ctrl;
    logic       locked;
    logic [3:0] offset;
`ifdef TMDS_LOCK_STATS_EN
    logic [7:0] lock_loss_cnt;
    logic [7:0] slip_cnt;
`endif

    tmds_rx_decoder #(
        .LOCK_RUN     (LOCK_RUN),
        .SLIP_TIMEOUT (SLIP_TIMEOUT),
        .LOST_TIMEOUT (LOST_TIMEOUT)
    ) dut (
        .clk_pix       (clk_pix),
        .rst_pix       (rst_pix),
        .sym_raw       (sym_raw),
        .data          (data),
        .de            (de),
        .ctrl          (ctrl),
        .locked        (locked),
        .offset        (offset)
`ifdef TMDS_LOCK_STATS_EN
        ,
        .lock_loss_cnt (lock_loss_cnt),
        .slip_cnt      (slip_cnt)
`endif
    );

    initial begin
        clk_pix = 1'b0;
        forever #5 clk_pix = ~clk_pix;
    end

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: received bits as one flat stream
    bit         stream[$];
    int         m_j;
    int         m_off;
    int         m_off_prev;
    int         m_run;
    int         m_miss;
    int         m_wd;
    bit         m_locked;
    logic [7:0] m_data;
    bit         m_de;
    logic [1:0] m_ctrl;
    int         m_losses;
    int         m_slips;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int tok_code(input logic [9:0] s);
        case (s)
            10'h354: return 0;
            10'h0AB: return 1;
            10'h154: return 2;
            10'h2AB: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic logic [7:0] ref_decode(input logic [9:0] s);
        logic [7:0] d;
        logic [7:0] q;
        d = s[9] ? ~s[7:0] : s[7:0];
        q[0] = d[0];
        for (int i = 1; i < 8; i++)
            q[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        return q;
    endfunction

    function automatic logic [9:0] extract(input int pos);
        logic [9:0] v;
        for (int i = 0; i < 10; i++) v[i] = stream[pos + i];
        return v;
    endfunction

    task automatic model_clear();
        stream.delete();
        for (int i = 0; i < 10; i++) stream.push_back(1'b0);
        m_j = 0; m_off = 0; m_off_prev = 0;
        m_run = 0; m_miss = 0; m_wd = 0; m_locked = 0;
        m_data = '0; m_de = 0; m_ctrl = '0;
        m_losses = 0; m_slips = 0;
    endtask

    task automatic model_step();
        logic [9:0] s;
        int code;
        int new_off;
        s = (m_j == 0) ? 10'h000 : extract(10 * (m_j - 1) + m_off_prev);
        code = tok_code(s);
        new_off = m_off;
        if (!m_locked) begin
            if (code >= 0) m_run++;
            else begin m_run = 0; m_miss++; end
            if (m_run == LOCK_RUN) begin
                m_locked = 1; m_wd = 0;
            end else if (m_miss == SLIP_TIMEOUT) begin
                new_off = (m_off + 1) % 10;
                m_run = 0; m_miss = 0;
                if (m_slips < 255) m_slips++;
            end
        end else begin
            if (code >= 0) m_wd = 0;
            else m_wd++;
            if (m_wd == LOST_TIMEOUT) begin
                m_locked = 0; m_run = 0; m_miss = 0;
                if (m_losses < 255) m_losses++;
            end
        end
        if (!m_locked) begin
            m_de = 0; m_data = '0; m_ctrl = '0;
        end else if (code >= 0) begin
            m_de = 0; m_data = '0; m_ctrl = 2'(code);
        end else begin
            m_de = 1; m_data = ref_decode(s);
        end
        m_off_prev = m_off;
        m_off = new_off;
        m_j++;
    endtask

    task automatic tick(input logic [9:0] w);
        sym_raw = w;
        @(posedge clk_pix);
        for (int i = 0; i < 10; i++) stream.push_back(w[i]);
        model_step();
        #1;
        chk("cycle", {16'h0, data, de, ctrl, locked, offset},
            {16'h0, m_data, m_de, m_ctrl, m_locked, 4'(m_off)});
`ifdef TMDS_LOCK_STATS_EN
        chk("stats", {16'h0, lock_loss_cnt, slip_cnt},
            {16'h0, 8'(m_losses), 8'(m_slips)});
`endif
    endtask

    task automatic do_reset();
        rst_pix = 1'b1;
        repeat (2) @(posedge clk_pix);
        @(negedge clk_pix);
        rst_pix = 1'b0;
        model_clear();
    endtask

    // Called just after a tick: reset lands mid-cycle, no edge before check.
    task automatic async_reset_check(input string tag);
        #2;
        rst_pix = 1'b1;
        #1;
        chk(tag, {16'h0, data, de, ctrl, locked, offset}, 32'h0);
        do_reset();
    endtask

    function automatic logic [9:0] shifted_word(input int n);
        logic [9:0] w;
        logic [9:0] t;
        int b;
        t = 10'h354;
        for (int i = 0; i < 10; i++) begin
            b = 10 * n + i;
            w[i] = (b < 3) ? 1'b0 : t[(b - 3) % 10];
        end
        return w;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "time limit");
    end

    initial begin
        logic [9:0] dec_seq[5];
        logic [9:0] tok_tab[4];
        int prev_off;
        bit saw_wrap;
        int len;

        rst_pix = 1'b1;
        sym_raw = '0;
        model_clear();
        do_reset();
        chk("reset_state", {16'h0, data, de, ctrl, locked, offset}, 32'h0);

        // Aligned lock at offset 0
        for (int n = 1; n <= 200; n++) begin
            tick(10'h354);
            if (n == 17) chk("pre_lock", {31'h0, locked}, 32'h0);
            if (n == 18) chk("lock_rise", {31'h0, locked}, 32'h1);
        end
        chk("lock_ctrl", {30'h0, ctrl}, 32'h0);
        chk("lock_off", {28'h0, offset}, 32'h0);

        // Data decode while locked
        dec_seq = '{10'h100, 10'h2FF, 10'h2AB, 10'h354, 10'h354};
        for (int n = 0; n < 5; n++) begin
            tick(dec_seq[n]);
            if (n == 2) chk("dec_100", {23'h0, de, data}, {23'h0, 1'b1, 8'h00});
            if (n == 3) chk("dec_2ff", {23'h0, de, data}, {23'h0, 1'b1, 8'hFE});
            if (n == 4) chk("dec_2ab", {21'h0, de, ctrl, data},
                            {21'h0, 1'b0, 2'b11, 8'h00});
        end

        // Lock loss after LOST_TIMEOUT non-token symbols
        for (int n = 0; n < LOST_TIMEOUT + 1; n++) tick(10'h100);
        chk("loss_pre", {31'h0, locked}, 32'h1);
        tick(10'h100);
        chk("loss_drop", {28'h0, locked, de, 2'b00}, 32'h0);
        chk("loss_off", {28'h0, offset}, 32'h0);
`ifdef TMDS_LOCK_STATS_EN
        chk("loss_cnt", {24'h0, lock_loss_cnt}, 32'h1);
`endif

        // Stream delayed by 3 bits: slips 0..3 then locks
        do_reset();
        for (int n = 0; n < 6200; n++) begin
            tick(shifted_word(n));
            if (n + 1 == 2047) chk("shift_off0", {28'h0, offset}, 32'd0);
            if (n + 1 == 2048) chk("shift_off1", {28'h0, offset}, 32'd1);
            if (n + 1 == 4096) chk("shift_off2", {28'h0, offset}, 32'd2);
            if (n + 1 == 6144) chk("shift_off3", {28'h0, offset}, 32'd3);
            if (n + 1 == 6160) chk("shift_prelk", {31'h0, locked}, 32'h0);
            if (n + 1 == 6161) chk("shift_lock", {31'h0, locked}, 32'h1);
        end
        chk("shift_final", {25'h0, locked, ctrl, offset},
            {25'h0, 1'b1, 2'b00, 4'd3});
`ifdef TMDS_LOCK_STATS_EN
        chk("slip_cnt", {24'h0, slip_cnt}, 32'd3);
`endif
        async_reset_check("async_reset");

        // Wrap: drive offset to 9 with idle data, then aligned tokens
        for (int n = 0; n < 9 * SLIP_TIMEOUT; n++) tick(10'h100);
        chk("wrap_at9", {28'h0, offset}, 32'd9);
        saw_wrap = 0;
        for (int n = 0; n < 4000 && !locked; n++) begin
            prev_off = int'(offset);
            tick(10'h354);
            if (prev_off == 9 && offset == 4'd0) saw_wrap = 1;
        end
        chk("wrap_seen", {31'h0, saw_wrap}, 32'h1);
        chk("wrap_lock", {27'h0, locked, offset}, {27'h0, 1'b1, 4'd0});

        // Random bursts of tokens and data
        do_reset();
        tok_tab = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
        for (int n = 0; n < 20; n++) tick(tok_tab[$urandom_range(0, 3)]);
        for (int b = 0; b < 250; b++) begin
            if ($urandom_range(0, 2) != 0) begin
                len = $urandom_range(1, 20);
                for (int k = 0; k < len; k++)
                    tick(tok_tab[$urandom_range(0, 3)]);
            end else begin
                len = $urandom_range(1, 10);
                for (int k = 0; k < len; k++) tick(10'($urandom));
            end
        end
        for (int n = 0; n < 24; n++) tick(10'h2AB);
        chk("rand_lock", {29'h0, locked, ctrl}, {29'h0, 1'b1, 2'b11});
        async_reset_check("async_reset2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
